// File: rtl/writeback_arbiter_if.sv
// Bundle of the pipe / long-unit result buses, the RegisterFile write port and the
// decode query/forward signals seen by writeback_arbiter.
interface writeback_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  pipeValid;
    logic [ADDR_WIDTH-1:0] pipeReg;
    logic [DATA_WIDTH-1:0] pipeData;
    logic                  longValid;
    logic [ADDR_WIDTH-1:0] longReg;
    logic [DATA_WIDTH-1:0] longData;
    logic                  longReady;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  regWrite;
    logic [ADDR_WIDTH-1:0] queryReg;
    logic                  queryPending;
    logic                  fwdHit;
    logic [DATA_WIDTH-1:0] fwdData;

    modport slave (
        input  pipeValid, pipeReg, pipeData, longValid, longReg, longData, queryReg,
        output longReady, writeReg, writeData, regWrite, queryPending, fwdHit, fwdData
    );

    modport master (
        output pipeValid, pipeReg, pipeData, longValid, longReg, longData, queryReg,
        input  longReady, writeReg, writeData, regWrite, queryPending, fwdHit, fwdData
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Owns the RegisterFile write port: pipe results win, long-latency results are queued
// in order, with a pending-register query and a forward of the write being committed.
module writeback_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input logic                clk,
    input logic                rst_n,
    writeback_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(QUEUE_DEPTH);

    logic [ADDR_WIDTH-1:0]  entryReg  [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]  entryData [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] entryValid;
    logic [PtrW-1:0]        rdPtr;
    logic [PtrW-1:0]        wrPtr;
    logic [CntW-1:0]        count;
    logic [CntW-1:0]        countD;

    logic [ADDR_WIDTH-1:0]  writeRegQ, writeRegD;
    logic [DATA_WIDTH-1:0]  writeDataQ, writeDataD;
    logic                   regWriteQ, regWriteD;

    logic pipeIssue, longAccept, longKeep, fifoEmpty, pop, bypass, push, pendHit;

    assign pipeIssue  = bus.pipeValid && (bus.pipeReg != '0);
    assign bus.longReady = rst_n && (count < Full);
    assign longAccept = bus.longValid && bus.longReady;
    // A same-cycle pipe write to the same register is younger, so the long result is dead.
    assign longKeep   = longAccept && (bus.longReg != '0)
                        && !(pipeIssue && (bus.longReg == bus.pipeReg));
    assign fifoEmpty  = (count == '0);
    assign pop        = !pipeIssue && !fifoEmpty;
    assign bypass     = !pipeIssue && fifoEmpty && longKeep;
    assign push       = longKeep && !bypass;

    always_comb begin
        writeRegD  = writeRegQ;
        writeDataD = writeDataQ;
        regWriteD  = 1'b0;
        if (pipeIssue) begin
            regWriteD  = 1'b1;
            writeRegD  = bus.pipeReg;
            writeDataD = bus.pipeData;
        end else if (pop) begin
            // A squashed head still drains its slot but produces no write.
            if (entryValid[rdPtr]) begin
                regWriteD  = 1'b1;
                writeRegD  = entryReg[rdPtr];
                writeDataD = entryData[rdPtr];
            end
        end else if (bypass) begin
            regWriteD  = 1'b1;
            writeRegD  = bus.longReg;
            writeDataD = bus.longData;
        end
    end

    always_comb begin
        countD = count;
        unique case ({push, pop})
            2'b10:   countD = count + CntW'(1);
            2'b01:   countD = count - CntW'(1);
            default: countD = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeRegQ  <= '0;
            writeDataQ <= '0;
            regWriteQ  <= 1'b0;
            entryValid <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
        end else begin
            writeRegQ  <= writeRegD;
            writeDataQ <= writeDataD;
            regWriteQ  <= regWriteD;
            count      <= countD;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                if (pipeIssue && (entryReg[i] == bus.pipeReg)) begin
                    entryValid[i] <= 1'b0;
                end
            end
            if (pop) begin
                entryValid[rdPtr] <= 1'b0;
                rdPtr             <= rdPtr + PtrW'(1);
            end
            if (push) begin
                entryValid[wrPtr] <= 1'b1;
                wrPtr             <= wrPtr + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entryReg[wrPtr]  <= bus.longReg;
            entryData[wrPtr] <= bus.longData;
        end
    end

    always_comb begin
        pendHit = 1'b0;
        for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
            if (entryValid[i] && (entryReg[i] == bus.queryReg)) begin
                pendHit = 1'b1;
            end
        end
    end

    assign bus.queryPending = pendHit && (bus.queryReg != '0);
    assign bus.writeReg     = writeRegQ;
    assign bus.writeData    = writeDataQ;
    assign bus.regWrite     = regWriteQ;
    assign bus.fwdHit       = regWriteQ && (writeRegQ == bus.queryReg) && (bus.queryReg != '0);
    assign bus.fwdData      = writeDataQ;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: single-cycle vector table plus multi-cycle sequences,
// every commit checked in order against a queue of expected writes.
module tb_writeback_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    writeback_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        bit            pv;
        logic [AW-1:0] pr;
        logic [DW-1:0] pd;
        bit            lv;
        logic [AW-1:0] lr;
        logic [DW-1:0] ld;
        logic [AW-1:0] qr;
        bit            expWr;
        logic [AW-1:0] expReg;
        logic [DW-1:0] expData;
        bit            expFwd;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];
    wr_t  expQ [$];
    wr_t  monWr;
    int   tests = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipeValid = 1'b0;
        bus.longValid = 1'b0;
    endtask

    task automatic expect_write(input logic [AW-1:0] r, input logic [DW-1:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        expQ.push_back(w);
    endtask

    // Every committed write must be the next one the bench expects.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.regWrite === 1'b1) begin
            tests++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL spurious_write: got r%0d=%h, required no write",
                         bus.writeReg, bus.writeData);
            end else begin
                monWr = expQ.pop_front();
                if (bus.writeReg !== monWr.r || bus.writeData !== monWr.d) begin
                    failures++;
                    $display("FAIL commit_order: got r%0d=%h, required r%0d=%h",
                             bus.writeReg, bus.writeData, monWr.r, monWr.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{1, 5'd10, 32'hFFFFFFFF, 0, 5'd0,  32'h0,    5'd10, 1, 5'd10, 32'hFFFFFFFF, 1};
        vec[1] = '{1, 5'd0,  32'h1234,     0, 5'd0,  32'h0,    5'd0,  0, 5'd0,  32'h0,        0};
        vec[2] = '{0, 5'd0,  32'h0,        1, 5'd12, 32'h1200, 5'd12, 1, 5'd12, 32'h1200,     1};
        vec[3] = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h5678, 5'd0,  0, 5'd0,  32'h0,        0};
        vec[4] = '{1, 5'd31, 32'h0,        0, 5'd0,  32'h0,    5'd31, 1, 5'd31, 32'h0,        1};
        vec[5] = '{1, 5'd7,  32'hABCD,     0, 5'd0,  32'h0,    5'd7,  1, 5'd7,  32'hABCD,     1};
        vec[6] = '{1, 5'd7,  32'hABCD,     0, 5'd0,  32'h0,    5'd8,  1, 5'd7,  32'hABCD,     0};
        vec[7] = '{1, 5'd0,  32'h1234,     1, 5'd9,  32'h99,   5'd9,  1, 5'd9,  32'h99,       1};

        // Reset with the long unit offering a result.
        rst_n = 1'b0;
        bus.pipeValid = 1'b0; bus.pipeReg = '0; bus.pipeData = '0;
        bus.longValid = 1'b1; bus.longReg = 5'd3; bus.longData = 32'h33;
        bus.queryReg = 5'd3;
        tick(); tick();
        check("rst_regWrite", 64'(bus.regWrite), 64'(0));
        check("rst_longReady", 64'(bus.longReady), 64'(0));
        check("rst_writeReg", 64'(bus.writeReg), 64'(0));
        check("rst_writeData", 64'(bus.writeData), 64'(0));
        check("rst_pending", 64'(bus.queryPending), 64'(0));
        idle();
        rst_n = 1'b1;
        tick();
        check("post_rst_longReady", 64'(bus.longReady), 64'(1));
        check("post_rst_regWrite", 64'(bus.regWrite), 64'(0));

        // Single-cycle vectors, each followed by an idle cycle.
        for (int i = 0; i < NV; i++) begin
            bus.pipeValid = vec[i].pv; bus.pipeReg = vec[i].pr; bus.pipeData = vec[i].pd;
            bus.longValid = vec[i].lv; bus.longReg = vec[i].lr; bus.longData = vec[i].ld;
            bus.queryReg  = vec[i].qr;
            if (vec[i].expWr) expect_write(vec[i].expReg, vec[i].expData);
            check("vec_longReady", 64'(bus.longReady), 64'(1));
            tick();
            idle();
            check("vec_regWrite", 64'(bus.regWrite), 64'(vec[i].expWr));
            check("vec_fwdHit", 64'(bus.fwdHit), 64'(vec[i].expFwd));
            check("vec_pending", 64'(bus.queryPending), 64'(0));
            if (vec[i].expFwd) check("vec_fwdData", 64'(bus.fwdData), 64'(vec[i].expData));
            if (vec[i].expWr) check("vec_writeReg", 64'(bus.writeReg), 64'(vec[i].expReg));
            tick();
        end

        // Contention: three pipe writes while two long results queue up behind them.
        expect_write(5'd20, 32'hFFFFFFFE);
        expect_write(5'd20, 32'hFFFFFFFE);
        expect_write(5'd20, 32'hFFFFFFFE);
        expect_write(5'd30, 32'hFFFFFFFD);
        expect_write(5'd31, 32'd7);
        bus.pipeValid = 1'b1; bus.pipeReg = 5'd20; bus.pipeData = 32'hFFFFFFFE;
        bus.longValid = 1'b1; bus.longReg = 5'd30; bus.longData = 32'hFFFFFFFD;
        bus.queryReg = 5'd30;
        tick();
        check("cont_pending_1", 64'(bus.queryPending), 64'(1));
        check("cont_ready_1", 64'(bus.longReady), 64'(1));
        bus.longReg = 5'd31; bus.longData = 32'd7;
        tick();
        check("cont_ready_full", 64'(bus.longReady), 64'(0));
        check("cont_pending_2", 64'(bus.queryPending), 64'(1));
        bus.longValid = 1'b0;
        tick();
        check("cont_pending_3", 64'(bus.queryPending), 64'(1));
        bus.pipeValid = 1'b0;
        tick();
        check("cont_r30_reg", 64'(bus.writeReg), 64'(30));
        check("cont_pending_clear", 64'(bus.queryPending), 64'(0));
        check("cont_fwdHit", 64'(bus.fwdHit), 64'(1));
        check("cont_fwdData", 64'(bus.fwdData), 64'(32'hFFFFFFFD));
        tick();
        check("cont_r31_reg", 64'(bus.writeReg), 64'(31));
        check("cont_ready_drained", 64'(bus.longReady), 64'(1));
        tick();
        check("cont_idle", 64'(bus.regWrite), 64'(0));

        // WAW squash: queued r5 killed by a younger pipe write; r8 behind it still commits.
        expect_write(5'd6, 32'h66);
        expect_write(5'd7, 32'h77);
        expect_write(5'd5, 32'h22);
        expect_write(5'd8, 32'h88);
        bus.queryReg = 5'd5;
        bus.pipeValid = 1'b1; bus.pipeReg = 5'd6; bus.pipeData = 32'h66;
        bus.longValid = 1'b1; bus.longReg = 5'd5; bus.longData = 32'h11;
        tick();
        check("waw_pending_set", 64'(bus.queryPending), 64'(1));
        bus.pipeReg = 5'd7; bus.pipeData = 32'h77;
        bus.longReg = 5'd8; bus.longData = 32'h88;
        tick();
        bus.longValid = 1'b0;
        bus.pipeReg = 5'd5; bus.pipeData = 32'h22;
        tick();
        check("waw_pending_clear", 64'(bus.queryPending), 64'(0));
        check("waw_fwdData", 64'(bus.fwdData), 64'(32'h22));
        bus.pipeValid = 1'b0;
        tick();
        check("waw_squashed_pop", 64'(bus.regWrite), 64'(0));
        check("waw_squashed_fwd", 64'(bus.fwdHit), 64'(0));
        tick();
        check("waw_next_pop", 64'(bus.regWrite), 64'(1));
        check("waw_next_reg", 64'(bus.writeReg), 64'(8));
        tick();
        check("waw_idle", 64'(bus.regWrite), 64'(0));
        check("waw_ready", 64'(bus.longReady), 64'(1));

        check("scoreboard_drained", 64'(expQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
